// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-RAM arbiter and the memory controller.
package dmem_arbiter_pkg;

  // Which requester owns the RAM port this cycle
  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_CPU  = 2'd1;
  localparam logic [1:0] GNT_DMA  = 2'd2;

  // Byte-address bit that selects the I/O space instead of the data RAM
  localparam int IO_BIT = 31;

  // Width of the DMA starvation counter
  localparam int WAIT_W = 4;

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating up-counter used to bound how long the DMA can be denied.
module dmem_arbiter_starve_counter #(
  parameter int W     = 4,
  parameter int LIMIT = 4
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         at_limit
);

  localparam logic [W-1:0] LIM = W'(LIMIT);

  assign at_limit = (cnt == LIM);

  // Clear wins over increment; the count holds once it reaches the limit
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_limit) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Fixed-priority arbiter sharing the single-port data RAM between the CPU
// MEM stage and the DMA/loader port. The CPU wins unless the DMA has been
// denied MAX_WAIT cycles in a row, in which case the DMA is forced through
// and the CPU stalls for one cycle.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW       = 5,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [31:0]   cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_rvalid,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rdata
);

  logic              cpu_mem;
  logic [AW-1:0]     cpu_word;
  logic [1:0]        grant_sel;
  logic              grant_cpu;
  logic              grant_dma;
  logic              starved;
  logic [WAIT_W-1:0] wait_cnt;
  logic              rd_cpu;
  logic              rd_dma;
  logic              we_sel;
  logic              unused_addr;

  // I/O accesses never touch the RAM, so they neither win nor stall
  assign cpu_mem     = cpu_req & ~cpu_addr[IO_BIT];
  assign cpu_word    = cpu_addr[AW+1:2];
  assign unused_addr = ^{cpu_addr[30:AW+2], cpu_addr[1:0]};

  dmem_arbiter_starve_counter #(
    .W     (WAIT_W),
    .LIMIT (MAX_WAIT)
  ) u_starve (
    .clock    (clock),
    .resetn   (resetn),
    .clr      (grant_dma | ~dma_req),
    .inc      (dma_req & ~grant_dma),
    .cnt      (wait_cnt),
    .at_limit (starved)
  );

  // Priority: starved DMA, then CPU, then DMA
  always_comb begin
    grant_sel = GNT_NONE;
    if (dma_req && starved) begin
      grant_sel = GNT_DMA;
    end else if (cpu_mem) begin
      grant_sel = GNT_CPU;
    end else if (dma_req) begin
      grant_sel = GNT_DMA;
    end
  end

  assign grant_cpu = (grant_sel == GNT_CPU);
  assign grant_dma = (grant_sel == GNT_DMA);
  assign cpu_stall = cpu_mem & ~grant_cpu;
  assign dma_gnt   = grant_dma;

  // Steer the winner's fields onto the RAM port; idle port drives zeros
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    we_sel    = 1'b0;
    case (grant_sel)
      GNT_CPU: begin
        ram_addr  = cpu_word;
        ram_wdata = cpu_wdata;
        we_sel    = cpu_we;
      end
      GNT_DMA: begin
        ram_addr  = dma_addr;
        ram_wdata = dma_wdata;
        we_sel    = dma_we;
      end
      default: begin
        ram_addr  = '0;
        ram_wdata = '0;
        we_sel    = 1'b0;
      end
    endcase
  end

  // No RAM writes can slip through while reset is held
  assign ram_we = we_sel & resetn;

  // Remember who issued a read so the returning data is tagged next cycle
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_cpu <= 1'b0;
      rd_dma <= 1'b0;
    end else begin
      rd_cpu <= grant_cpu & ~cpu_we;
      rd_dma <= grant_dma & ~dma_we;
    end
  end

  assign cpu_rvalid = rd_cpu;
  assign dma_rvalid = rd_dma;
  assign cpu_rdata  = ram_rdata;
  assign dma_rdata  = ram_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural RAM and a read scoreboard.
module tb_dmem_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clock;
  logic          resetn;
  logic          cpu_req;
  logic          cpu_we;
  logic [31:0]   cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;
  logic          cpu_stall;
  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt;
  logic [DW-1:0] dma_rdata;
  logic          dma_rvalid;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic [DW-1:0] ram_rdata;

  logic          preload;
  logic [DW-1:0] mem [32];
  logic [DW-1:0] exp_mem [32];

  int n_assert = 0;
  int n_fail   = 0;

  logic [DW-1:0] cpu_q [$];
  logic [DW-1:0] dma_q [$];
  logic          pend_cpu = 1'b0;
  logic          pend_dma = 1'b0;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .cpu_stall  (cpu_stall),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rdata  (dma_rdata),
    .dma_rvalid (dma_rvalid),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_rdata  (ram_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous single-port RAM with registered read data
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hA5A5_0000 + 32'(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and score any read returns
  task automatic tick();
    logic [DW-1:0] e;
    @(negedge clock);
    check("cpu_rvalid", 32'(cpu_rvalid), 32'(pend_cpu));
    check("dma_rvalid", 32'(dma_rvalid), 32'(pend_dma));
    if (pend_cpu && cpu_q.size() > 0) begin
      e = cpu_q.pop_front();
      check("cpu_rdata", cpu_rdata, e);
    end
    if (pend_dma && dma_q.size() > 0) begin
      e = dma_q.pop_front();
      check("dma_rdata", dma_rdata, e);
    end
    pend_cpu = 1'b0;
    pend_dma = 1'b0;
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic dr, input logic dw, input logic [4:0] da, input logic [31:0] dd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
  endtask

  initial begin
    int cpu_k;
    logic exp_dma;
    for (int i = 0; i < 32; i++) exp_mem[i] = 32'hA5A5_0000 + 32'(i);
    resetn  = 1'b0;
    preload = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
    check("rst_wait_cnt", 32'(dut.wait_cnt), 32'd0);

    // CPU write plus DMA request during reset: RAM write suppressed, CPU wins
    tick();
    drive(1'b1, 1'b1, 32'h0000_0008, 32'h1111_1111, 1'b1, 1'b0, 5'd1, 32'h0);
    #1;
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_cpu_stall", 32'(cpu_stall), 32'd0);
    check("rst_dma_gnt", 32'(dma_gnt), 32'd0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    resetn  = 1'b1;
    preload = 1'b0;

    // CPU-only read of word 4
    tick();
    drive(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    check("cpu_rd_addr", 32'(ram_addr), 32'd4);
    check("cpu_rd_we", 32'(ram_we), 32'd0);
    check("cpu_rd_stall", 32'(cpu_stall), 32'd0);
    cpu_q.push_back(exp_mem[4]); pend_cpu = 1'b1;
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    check("idle_ram_addr", 32'(ram_addr), 32'd0);
    check("idle_ram_we", 32'(ram_we), 32'd0);

    // DMA write then read back of word 7
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF);
    #1;
    check("dma_wr_gnt", 32'(dma_gnt), 32'd1);
    check("dma_wr_we", 32'(ram_we), 32'd1);
    check("dma_wr_addr", 32'(ram_addr), 32'd7);
    check("dma_wr_data", ram_wdata, 32'hDEAD_BEEF);
    exp_mem[7] = 32'hDEAD_BEEF;
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd7, 32'h0);
    #1;
    check("dma_rd_gnt", 32'(dma_gnt), 32'd1);
    check("dma_rd_we", 32'(ram_we), 32'd0);
    dma_q.push_back(exp_mem[7]); pend_dma = 1'b1;

    // Contention: CPU wins four cycles, DMA forced through on the fifth
    cpu_k = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      drive(1'b1, 1'b0, 32'(8 + cpu_k) << 2, 32'h0, (c <= 4), 1'b0, 5'd3, 32'h0);
      #1;
      exp_dma = (c == 4);
      check($sformatf("cont%0d_wait", c), 32'(dut.wait_cnt), (c <= 4) ? 32'(c) : 32'd0);
      check($sformatf("cont%0d_gnt", c), 32'(dma_gnt), 32'(exp_dma));
      check($sformatf("cont%0d_stall", c), 32'(cpu_stall), 32'(exp_dma));
      check($sformatf("cont%0d_addr", c), 32'(ram_addr), exp_dma ? 32'd3 : 32'(8 + cpu_k));
      if (exp_dma) begin
        dma_q.push_back(exp_mem[3]); pend_dma = 1'b1;
      end else begin
        cpu_q.push_back(exp_mem[8 + cpu_k]); pend_cpu = 1'b1;
        cpu_k++;
      end
    end

    // I/O access bypasses arbitration; DMA gets the RAM
    tick();
    drive(1'b1, 1'b1, 32'h8000_000C, 32'h5555_5555, 1'b1, 1'b0, 5'd9, 32'h0);
    #1;
    check("io_dma_gnt", 32'(dma_gnt), 32'd1);
    check("io_cpu_stall", 32'(cpu_stall), 32'd0);
    check("io_ram_addr", 32'(ram_addr), 32'd9);
    check("io_ram_we", 32'(ram_we), 32'd0);
    dma_q.push_back(exp_mem[9]); pend_dma = 1'b1;

    // CPU write to word 0, no rvalid afterwards, then read it back
    tick();
    drive(1'b1, 1'b1, 32'h0000_0000, 32'h1234_5678, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    check("cpu_wr_we", 32'(ram_we), 32'd1);
    check("cpu_wr_addr", 32'(ram_addr), 32'd0);
    check("cpu_wr_data", ram_wdata, 32'h1234_5678);
    exp_mem[0] = 32'h1234_5678;
    tick();
    drive(1'b1, 1'b0, 32'h0000_0000, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    cpu_q.push_back(exp_mem[0]); pend_cpu = 1'b1;

    // Reset lands between a granted CPU read and its return
    tick();
    drive(1'b1, 1'b0, 32'h0000_0014, 32'h0, 1'b1, 1'b0, 5'd2, 32'h0);
    #1;
    check("rstmid_addr", 32'(ram_addr), 32'd5);
    check("rstmid_dma_gnt", 32'(dma_gnt), 32'd0);
    #2;
    resetn = 1'b0;
    cpu_we = 1'b1;
    #1;
    check("rstmid_ram_we", 32'(ram_we), 32'd0);
    tick();
    check("rstmid_wait", 32'(dut.wait_cnt), 32'd0);
    check("rstmid_ram_we2", 32'(ram_we), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    resetn = 1'b1;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
